// File: rtl/writeback_ledger_if.sv
// writeback_ledger_if: alloc / writeback / flush / retire bundle
// between rename, execution units and the ledger.
interface writeback_ledger_if #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 5,
  parameter int NR_W  = 4
);
  localparam int IW = $clog2(DEPTH);

  logic             alloc_valid;
  logic [TAG_W-1:0] alloc_tag;
  logic [NR_W-1:0]  alloc_nr;
  logic             alloc_ready;
  logic [IW-1:0]    alloc_idx;
  logic             wb_valid;
  logic [IW-1:0]    wb_idx;
  logic             flush;
  logic             retire_valid;
  logic [TAG_W-1:0] retire_tag;
  logic [NR_W-1:0]  retire_nr;
  logic [IW:0]      count;
  logic             empty;

  modport master (
    output alloc_valid, alloc_tag, alloc_nr,
    output wb_valid, wb_idx, flush,
    input  alloc_ready, alloc_idx,
    input  retire_valid, retire_tag, retire_nr,
    input  count, empty
  );

  modport slave (
    input  alloc_valid, alloc_tag, alloc_nr,
    input  wb_valid, wb_idx, flush,
    output alloc_ready, alloc_idx,
    output retire_valid, retire_tag, retire_nr,
    output count, empty
  );
endinterface

// File: rtl/writeback_ledger.sv
// writeback_ledger: in-order tag release ledger for the renamer.
// Optional LEDGER_BYPASS_EN: a wb hitting the head retires same edge.
module writeback_ledger #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 5,
  parameter int NR_W  = 4
) (
  input logic               clk,
  input logic               rst,
  writeback_ledger_if.slave bus
);
  localparam int IW = $clog2(DEPTH);

  logic [IW:0]      head;
  logic [IW:0]      tail;
  logic [IW:0]      cnt;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] dne;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [NR_W-1:0]  nr_q  [DEPTH];

  logic             rv_q;
  logic [TAG_W-1:0] rtag_q;
  logic [NR_W-1:0]  rnr_q;

  logic [IW-1:0] hidx;
  logic [IW-1:0] tidx;
  logic          rdy;
  logic          do_alloc;
  logic          do_wb;
  logic          rt_norm;
  logic          rt_byp;
  logic          do_ret;

  // Pointer arithmetic, handshake and retire decisions.
  always_comb begin
    hidx     = head[IW-1:0];
    tidx     = tail[IW-1:0];
    cnt      = tail - head;
    rdy      = (cnt != (IW+1)'(DEPTH));
    do_alloc = bus.alloc_valid && rdy;
    do_wb    = bus.wb_valid && vld[bus.wb_idx];
    rt_norm  = vld[hidx] && dne[hidx];
`ifdef LEDGER_BYPASS_EN
    rt_byp   = !rt_norm && vld[hidx] &&
               bus.wb_valid && (bus.wb_idx == hidx);
`else
    rt_byp   = 1'b0;
`endif
    do_ret   = rt_norm || rt_byp;
  end

  // Output drive from registered state.
  always_comb begin
    bus.alloc_ready  = rdy;
    bus.alloc_idx    = tidx;
    bus.count        = cnt;
    bus.empty        = (cnt == '0);
    bus.retire_valid = rv_q;
    bus.retire_tag   = rtag_q;
    bus.retire_nr    = rnr_q;
  end

  // Pointers, entry flags and the retire pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      head   <= '0;
      tail   <= '0;
      vld    <= '0;
      dne    <= '0;
      rv_q   <= 1'b0;
      rtag_q <= '0;
      rnr_q  <= '0;
    end else if (bus.flush) begin
      head <= '0;
      tail <= '0;
      vld  <= '0;
      dne  <= '0;
      rv_q <= 1'b0;
    end else begin
      rv_q <= do_ret;
      if (do_ret) begin
        rtag_q <= tag_q[hidx];
        rnr_q  <= nr_q[hidx];
        head   <= head + 1'b1;
      end
      if (do_alloc)
        tail <= tail + 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (do_wb && bus.wb_idx == IW'(i))
          dne[i] <= 1'b1;
        if (do_alloc && tidx == IW'(i)) begin
          vld[i] <= 1'b1;
          dne[i] <= 1'b0;
        end
        if (do_ret && hidx == IW'(i)) begin
          vld[i] <= 1'b0;
          dne[i] <= 1'b0;
        end
      end
    end
  end

  // Payload storage, written on accepted alloc only.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && do_alloc) begin
      tag_q[tidx] <= bus.alloc_tag;
      nr_q[tidx]  <= bus.alloc_nr;
    end
  end
endmodule

// File: tb/tb_writeback_ledger.sv
// tb_writeback_ledger: queue-based reference model, scoreboard
// of expected retires, directed scenarios then random traffic.
module tb_writeback_ledger;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  writeback_ledger_if #(.DEPTH(D), .TAG_W(5), .NR_W(4)) bus ();

  writeback_ledger #(.DEPTH(D), .TAG_W(5), .NR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int tag;
    int nr;
    bit done;
  } ent_t;

  typedef struct {
    int tag;
    int nr;
    int at;
  } exp_t;

  ent_t ents[$];
  int   hptr = 0;
  exp_t sb[$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Apply one cycle of stimulus and advance the model over that edge.
  task automatic step(input bit av, input int t, input int n,
                      input bit wv, input int wi,
                      input bit fl, input bit r);
    int  sz;
    int  k;
    bit  ret;
    @(negedge clk);
    sz = ents.size();
    chk("count", int'(bus.count), sz);
    chk("empty", int'(bus.empty), int'(sz == 0));
    chk("alloc_ready", int'(bus.alloc_ready), int'(sz < D));
    chk("alloc_idx", int'(bus.alloc_idx), (hptr + sz) % D);
    bus.alloc_valid = av;
    bus.alloc_tag   = 5'(t);
    bus.alloc_nr    = 4'(n);
    bus.wb_valid    = wv;
    bus.wb_idx      = 3'(wi);
    bus.flush       = fl;
    rst             = r;
    if (r || fl) begin
      ents.delete();
      hptr = 0;
    end else begin
      ret = (sz > 0) && ents[0].done;
`ifdef LEDGER_BYPASS_EN
      if (!ret && sz > 0 && wv && (wi % D) == hptr)
        ret = 1'b1;
`endif
      k = ((wi % D) - hptr + D) % D;
      if (wv && k < sz)
        ents[k].done = 1'b1;
      if (ret) begin
        sb.push_back('{ents[0].tag, ents[0].nr, cyc + 1});
        void'(ents.pop_front());
        hptr = (hptr + 1) % D;
      end
      if (av && sz < D)
        ents.push_back('{t, n, 1'b0});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset1();
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  // Monitor: every retire pulse must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.retire_valid) begin
        if (sb.size() == 0) begin
          chk("retire_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("retire_tag", int'(bus.retire_tag), e.tag);
          chk("retire_nr", int'(bus.retire_nr), e.nr);
          chk("retire_cycle", cyc, e.at);
        end
      end else if (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        chk("retire_missing", 0, 1);
      end
    end
  end

  initial begin
    int sz;
    int wi;
    bus.alloc_valid = 1'b0;
    bus.alloc_tag   = '0;
    bus.alloc_nr    = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_idx      = '0;
    bus.flush       = 1'b0;

    // 1: in-order alloc and completion
    reset1();
    step(1, 3, 1, 0, 0, 0, 0);
    step(1, 4, 2, 0, 0, 0, 0);
    step(1, 5, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 2, 0, 0);
    idle(3);

    // 2: reverse completion, head-of-line blocking
    reset1();
    step(1, 10, 4, 0, 0, 0, 0);
    step(1, 11, 5, 0, 0, 0, 0);
    step(1, 12, 6, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(4);

    // 3: full, alloc refused alongside retire, tail wrap
    reset1();
    for (int i = 0; i < D; i++)
      step(1, 16 + i, i, 0, 0, 0, 0);
    step(1, 30, 9, 1, 0, 0, 0);
    step(1, 31, 10, 0, 0, 0, 0);
    step(1, 29, 11, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i < D + 2; i++)
      step(0, 0, 0, 1, i % D, 0, 0);
    idle(4);

    // 4: flush discards alloc and wb of that cycle
    reset1();
    for (int i = 0; i < 4; i++)
      step(1, 1 + i, i, 0, 0, 0, 0);
    step(1, 7, 7, 1, 0, 1, 0);
    idle(3);

    // 5: wb to invalid slot ignored
    reset1();
    step(0, 0, 0, 1, 5, 0, 0);
    for (int i = 0; i < 6; i++)
      step(1, 20 + i, i, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 1, i, 0, 0);
    idle(3);
    step(0, 0, 0, 1, 5, 0, 0);
    idle(3);

    // 6: retire latency from wb
    reset1();
    step(1, 9, 2, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(3);

    // random traffic
    reset1();
    for (int n = 0; n < 3000; n++) begin
      sz = ents.size();
      if ($urandom_range(99) < 70 && sz > 0)
        wi = (hptr + int'($urandom_range(sz - 1))) % D;
      else
        wi = int'($urandom_range(D - 1));
      step(($urandom_range(99) < ((n / 300) % 2 ? 80 : 45)),
           int'($urandom_range(31)), int'($urandom_range(15)),
           ($urandom_range(99) < ((n / 500) % 2 ? 20 : 55)), wi,
           ($urandom_range(99) == 0),
           ($urandom_range(499) == 0));
    end

    // drain
    for (int n = 0; n < 4 * D; n++)
      step(0, 0, 0, 1, n % D, 0, 0);
    idle(3);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
